q_update_seq: RTL

//  Sequencer for one Q-learning update. Fetches two rows from the 9 per-action Q RAMs:
//   - first the current-state row, then the next-state row.

---
 rtl/q_update_seq.sv | 123 ++++++++++++
 1 files changed

// File: rtl/q_update_seq.sv
// Sequencer for one Q-learning update: reads the Q(s,*) and Q(s',*) rows,
// feeds the datapath, then writes Q_new back to the RAM picked by the action.
module q_update_seq #(
  parameter int STATE_W = 18,
  parameter int DATA_W  = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  logic [STATE_W-1:0]    state_in,
  input  logic [STATE_W-1:0]    next_state_in,
  input  logic [3:0]            action_in,
  input  logic [DATA_W-1:0]     reward_in,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [DATA_W-1:0]     q_result,
  output logic [STATE_W-1:0]    ram_raddr,
  input  logic [9*DATA_W-1:0]   ram_rdata,
  output logic [8:0]            ram_we,
  output logic [STATE_W-1:0]    ram_waddr,
  output logic [DATA_W-1:0]     ram_wdata,
  output logic [9*DATA_W-1:0]   dp_data,
  output logic [3:0]            dp_action,
  output logic [DATA_W-1:0]     dp_reward,
  input  logic [DATA_W-1:0]     dp_q_new
);

  typedef enum logic [2:0] {
    IDLE,
    RD_S,
    RD_N,
    CAP_N,
    EVAL,
    WR,
    DONE
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [STATE_W-1:0]   s_q;
  logic [STATE_W-1:0]   sn_q;
  logic [STATE_W-1:0]   raddr_q;
  logic [9*DATA_W-1:0]  data_q;
  logic [3:0]           a_q;
  logic [DATA_W-1:0]    r_q;
  logic [DATA_W-1:0]    q_reg;
  logic [DATA_W-1:0]    q_res_q;
  logic                 legal;
  logic [8:0]           we_mask;

  assign legal   = (a_q != 4'd0) && (a_q <= 4'd9);
  assign we_mask = 9'd1 << (a_q - 4'd1);

  always_ff @(posedge clock) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RD_S;
      RD_S:    state_d = RD_N;
      RD_N:    state_d = CAP_N;
      CAP_N:   state_d = EVAL;
      EVAL:    state_d = WR;
      WR:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Write enable is gated by reset so a reset landing in WR never writes.
  always_comb begin
    busy   = (state_q != IDLE);
    done   = (state_q == DONE);
    err    = (state_q == DONE) && !legal;
    ram_we = '0;
    if (state_q == WR && legal && !reset)
      ram_we = we_mask;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s_q     <= '0;
      sn_q    <= '0;
      a_q     <= '0;
      r_q     <= '0;
      raddr_q <= '0;
      data_q  <= '0;
      q_reg   <= '0;
      q_res_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            s_q     <= state_in;
            sn_q    <= next_state_in;
            a_q     <= action_in;
            r_q     <= reward_in;
            raddr_q <= state_in;
          end
        end
        RD_S:  raddr_q <= sn_q;
        RD_N:  data_q  <= ram_rdata;
        CAP_N: data_q  <= ram_rdata;
        EVAL:  q_reg   <= dp_q_new;
        WR:    if (legal) q_res_q <= q_reg;
        default: ;
      endcase
    end
  end

  assign ram_raddr = raddr_q;
  assign ram_waddr = s_q;
  assign ram_wdata = q_reg;
  assign dp_data   = data_q;
  assign dp_action = a_q;
  assign dp_reward = r_q;
  assign q_result  = q_res_q;

endmodule
